// File: rtl/tmr_down_pkg.sv
// Shared definitions for the down-counting timer: FSM state encoding and default width.
package tmr_down_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HOLD    = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/tmr_prescaler.sv
// Divides the clock into one-cycle decrement ticks, one every PRESCALE enabled clocks.
// Holding en low freezes the phase; clr restarts it from zero.
module tmr_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tmr_down.sv
// Loadable down-counting timer with pause, abort and optional auto-reload.
// Commands resolve stop > start > pause; all outputs are registered.
module tmr_down
  import tmr_down_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             reload_en,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             expired
);

  state_t           state;
  logic [WIDTH-1:0] reload_val;
  logic             tick;
  logic             pre_clr;
  logic             pre_en;

  // The pausing edge itself must not advance the phase, hence !pause here.
  assign pre_clr = stop | start;
  assign pre_en  = (state == ST_RUN) && !pause;

  tmr_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (pre_clr),
    .en    (pre_en),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      count      <= '0;
      reload_val <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      expired    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state   <= ST_IDLE;
        count   <= '0;
        busy    <= 1'b0;
        expired <= 1'b0;
      end else if (start) begin
        reload_val <= load_val;
        if (load_val == '0) begin
          // A zero load expires immediately and never reloads.
          state   <= ST_EXPIRED;
          count   <= '0;
          done    <= 1'b1;
          busy    <= 1'b0;
          expired <= 1'b1;
        end else begin
          state   <= ST_RUN;
          count   <= load_val;
          busy    <= 1'b1;
          expired <= 1'b0;
        end
      end else begin
        case (state)
          ST_RUN: begin
            if (pause) begin
              state <= ST_HOLD;
            end else if (tick) begin
              if (count > WIDTH'(1)) begin
                count <= count - 1'b1;
              end else if (reload_en) begin
                count <= reload_val;
                done  <= 1'b1;
              end else begin
                state   <= ST_EXPIRED;
                count   <= '0;
                done    <= 1'b1;
                busy    <= 1'b0;
                expired <= 1'b1;
              end
            end
          end
          ST_HOLD: begin
            if (!pause) begin
              state <= ST_RUN;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
